uart_bram_ctrl: RTL and testbench

Sequencer between a `uart_rx` instance, a single-port `bram`, and a `uart_tx` instance. It replaces testbench-driven addressing with hardware control. In capture mode it writes each received byte to the next BRAM address. On a play command it reads the stored bytes back in order and hands them one at a time to the transmitter, honouring its ready handshake. It also owns the single BRAM address/write port, time-sharing it between capture and playback.

---
 rtl/uart_bram_pkg.sv | 16 +
 rtl/uart_bram_ctrl_tx_handshake.sv | 49 ++++
 rtl/uart_bram_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_bram_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bram_pkg.sv
// Shared types for the UART/BRAM capture-and-playback sequencer.
package uart_bram_pkg;

  localparam int lp_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LAT,
    LOAD,
    SEND,
    WBUSY,
    WDONE
  } t_ctrl_state;

endpackage

// File: rtl/uart_bram_ctrl_tx_handshake.sv
// Transmitter handshake: holds the byte and walks SEND -> WBUSY -> WDONE
// against the uart_tx ready flag, then reports completion.
module uart_tx_handshake
  import uart_bram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 start,
  input  logic [lp_BYTE_W-1:0] data,
  input  logic                 tx_ready,
  output logic                 tx_en,
  output logic [lp_BYTE_W-1:0] txdata,
  output logic                 done
);

  t_ctrl_state state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start)     state_nxt = SEND;
        SEND:    if (tx_ready)  state_nxt = WBUSY;
        WBUSY:   if (!tx_ready) state_nxt = WDONE;
        WDONE:   if (tx_ready)  state_nxt = IDLE;
        default:                state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    tx_en = (state == SEND)  && tx_ready && !clear;
    done  = (state == WDONE) && tx_ready && !clear;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        txdata <= '0;
    else if (start) txdata <= data;
  end

endmodule

// File: rtl/uart_bram_ctrl.sv
// Sequencer owning the single BRAM port: captures received bytes in IDLE and
// replays the stored buffer through uart_tx on a play command.
module uart_bram_ctrl
  import uart_bram_pkg::*;
#(
  parameter int p_DEPTH  = 4,
  parameter int p_ADDR_W = $clog2(p_DEPTH),
  parameter int p_CNT_W  = $clog2(p_DEPTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx_done,
  input  logic [lp_BYTE_W-1:0] i8_rxdata,
  input  logic                 i_play,
  input  logic                 i_clear,
  output logic [p_ADDR_W-1:0]  oN_bram_addr,
  output logic [lp_BYTE_W-1:0] o8_bram_datain,
  output logic                 o_bram_we,
  input  logic [lp_BYTE_W-1:0] i8_bram_dataout,
  output logic                 o_tx_en,
  output logic [lp_BYTE_W-1:0] o8_txdata,
  input  logic                 i_tx_ready,
  output logic [p_CNT_W-1:0]   oN_count,
  output logic                 o_full,
  output logic                 o_busy,
  output logic                 o_overflow,
  output logic                 o_play_done
);

  t_ctrl_state state, state_nxt;

  logic [p_ADDR_W-1:0]  wr_ptr, rd_ptr, waddr;
  logic [p_CNT_W-1:0]   count, count_eff;
  logic [lp_BYTE_W-1:0] wdata;
  logic                 we, overflow, play_pend, play_done;
  logic                 accept, start_req, last, hs_done;

  // count_eff includes a write issued last cycle but not yet counted
  assign count_eff = count + p_CNT_W'(we);
  assign accept    = i_rx_done && (state == IDLE) && !i_clear
                     && (count_eff != p_CNT_W'(p_DEPTH));
  assign start_req = (i_play || play_pend) && (state == IDLE) && !i_clear;
  assign last      = (p_CNT_W'(rd_ptr) == count - p_CNT_W'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // A play arriving with a byte is deferred until that byte's write cycle
  always_comb begin
    state_nxt = state;
    if (i_clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start_req && !accept && count_eff != '0) state_nxt = RD;
        RD:      state_nxt = LAT;
        LAT:     state_nxt = LOAD;
        LOAD:    state_nxt = SEND;
        SEND:    if (hs_done) state_nxt = last ? IDLE : RD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    oN_bram_addr   = (state == IDLE) ? waddr : rd_ptr;
    o8_bram_datain = wdata;
    o_bram_we      = we;
    oN_count       = count;
    o_full         = (count == p_CNT_W'(p_DEPTH));
    o_busy         = (state != IDLE);
    o_overflow     = overflow;
    o_play_done    = play_done;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      waddr     <= '0;
      wdata     <= '0;
      count     <= '0;
      we        <= 1'b0;
      overflow  <= 1'b0;
      play_pend <= 1'b0;
      play_done <= 1'b0;
    end else if (i_clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      we        <= 1'b0;
      overflow  <= 1'b0;
      play_pend <= 1'b0;
      play_done <= 1'b0;
    end else begin
      we <= accept;
      if (accept) begin
        waddr <= wr_ptr + p_ADDR_W'(we);
        wdata <= i8_rxdata;
      end
      if (we) begin
        wr_ptr <= wr_ptr + p_ADDR_W'(1);
        count  <= count + p_CNT_W'(1);
      end
      if (i_rx_done && !accept) overflow <= 1'b1;
      play_pend <= start_req && accept;
      play_done <= (start_req && !accept && count_eff == '0)
                   || ((state == SEND) && hs_done && last);
      if (state == IDLE && state_nxt == RD)
        rd_ptr <= '0;
      else if (state == SEND && hs_done && !last)
        rd_ptr <= rd_ptr + p_ADDR_W'(1);
    end
  end

  uart_tx_handshake u_hs (
    .clk      (i_clk),
    .rst      (i_rst),
    .clear    (i_clear),
    .start    ((state == LOAD) && !i_clear),
    .data     (i8_bram_dataout),
    .tx_ready (i_tx_ready),
    .tx_en    (o_tx_en),
    .txdata   (o8_txdata),
    .done     (hs_done)
  );

endmodule

// File: tb/tb_uart_bram_ctrl.sv
// Directed bench for uart_bram_ctrl with a behavioural BRAM and transmitter.
module tb_uart_bram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rxdata = '0;
  logic       play = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] bram_addr;
  logic [7:0] bram_datain;
  logic       bram_we;
  logic [7:0] bram_dataout = '0;
  logic       tx_en;
  logic [7:0] txdata;
  logic       tx_ready = 1'b1;
  logic [2:0] count;
  logic       full, busy, overflow, play_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_bram_ctrl #(.p_DEPTH(4)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_rx_done       (rx_done),
    .i8_rxdata       (rxdata),
    .i_play          (play),
    .i_clear         (clear),
    .oN_bram_addr    (bram_addr),
    .o8_bram_datain  (bram_datain),
    .o_bram_we       (bram_we),
    .i8_bram_dataout (bram_dataout),
    .o_tx_en         (tx_en),
    .o8_txdata       (txdata),
    .i_tx_ready      (tx_ready),
    .oN_count        (count),
    .o_full          (full),
    .o_busy          (busy),
    .o_overflow      (overflow),
    .o_play_done     (play_done)
  );

  logic [7:0] mem [4];
  logic [7:0] tx_log [64];
  int tx_en_cnt = 0, we_cnt = 0, done_cnt = 0, busy_cnt = 0;

  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_datain;
    bram_dataout <= mem[bram_addr];
    if (tx_en) begin
      tx_ready <= 1'b0;
      busy_cnt <= 6;
      tx_log[tx_en_cnt & 63] <= txdata;
      tx_en_cnt <= tx_en_cnt + 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_ready <= 1'b1;
    end
    if (bram_we)   we_cnt   <= we_cnt + 1;
    if (play_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [7:0] b, input logic [1:0] a, input logic [2:0] cnt_after);
    rx_done = 1'b1;
    rxdata  = b;
    tick();
    rx_done = 1'b0;
    check("cap_we", bram_we, 1'b1);
    check("cap_addr", bram_addr, a);
    check("cap_data", bram_datain, b);
    tick();
    check("cap_count", count, cnt_after);
    tick();
  endtask

  task automatic pulse_play();
    play = 1'b1;
    tick();
    play = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (play_done) seen = 1'b1;
      else tick();
    end
    check(tag, seen, 1'b1);
    tick();
  endtask

  initial begin
    int base_tx, base_we, base_done;
    bit seen;

    // reset values
    tick();
    check("rst_count", count, 3'd0);
    check("rst_full", full, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_we", bram_we, 1'b0);
    check("rst_addr", bram_addr, 2'd0);
    check("rst_txdata", txdata, 8'h00);
    check("rst_done", play_done, 1'b0);
    rst = 1'b0;
    tick();

    // capture three bytes
    capture(8'hFF, 2'd0, 3'd1);
    capture(8'hAA, 2'd1, 3'd2);
    capture(8'h55, 2'd2, 3'd3);
    check("cap_full", full, 1'b0);

    // playback
    base_tx = tx_en_cnt;
    base_done = done_cnt;
    pulse_play();
    check("rd_busy", busy, 1'b1);
    check("rd_addr", bram_addr, 2'd0);
    tick(); tick(); tick();
    check("send_tx_en", tx_en, 1'b1);
    check("send_txdata", txdata, 8'hFF);
    wait_done("play_done_seen");
    check("play_tx_cnt", tx_en_cnt - base_tx, 3);
    check("play_b0", tx_log[base_tx & 63], 8'hFF);
    check("play_b1", tx_log[(base_tx + 1) & 63], 8'hAA);
    check("play_b2", tx_log[(base_tx + 2) & 63], 8'h55);
    check("play_done_cnt", done_cnt - base_done, 1);
    check("play_busy_after", busy, 1'b0);
    check("play_count_kept", count, 3'd3);

    // overflow
    pulse_clear();
    check("clr_count", count, 3'd0);
    base_we = we_cnt;
    for (int i = 0; i < 5; i++) begin
      rx_done = 1'b1;
      rxdata  = 8'h10 + 8'(i);
      tick();
      rx_done = 1'b0;
      tick(); tick();
    end
    check("ovf_writes", we_cnt - base_we, 4);
    check("ovf_full", full, 1'b1);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_count", count, 3'd4);
    check("ovf_mem3", mem[3], 8'h13);

    // empty play
    pulse_clear();
    check("clr_ovf", overflow, 1'b0);
    base_tx = tx_en_cnt;
    pulse_play();
    check("empty_done", play_done, 1'b1);
    check("empty_busy", busy, 1'b0);
    tick(); tick(); tick(); tick(); tick();
    check("empty_no_tx", tx_en_cnt - base_tx, 0);

    // abort during second byte
    capture(8'h11, 2'd0, 3'd1);
    capture(8'h22, 2'd1, 3'd2);
    capture(8'h33, 2'd2, 3'd3);
    base_tx = tx_en_cnt;
    pulse_play();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (tx_en_cnt - base_tx == 2) seen = 1'b1;
      else tick();
    end
    check("abort_reach_b2", seen, 1'b1);
    pulse_clear();
    check("abort_busy", busy, 1'b0);
    check("abort_count", count, 3'd0);
    for (int i = 0; i < 30; i++) tick();
    check("abort_no_more_tx", tx_en_cnt - base_tx, 2);
    capture(8'h44, 2'd0, 3'd1);

    // rx during playback
    base_we = we_cnt;
    pulse_play();
    rx_done = 1'b1;
    rxdata  = 8'h99;
    tick();
    rx_done = 1'b0;
    wait_done("rxplay_done");
    check("rxplay_no_write", we_cnt - base_we, 0);
    check("rxplay_ovf", overflow, 1'b1);
    check("rxplay_count", count, 3'd1);

    // clear together with play
    base_tx = tx_en_cnt;
    base_done = done_cnt;
    clear = 1'b1;
    play  = 1'b1;
    tick();
    clear = 1'b0;
    play  = 1'b0;
    check("clrplay_busy", busy, 1'b0);
    tick(); tick(); tick(); tick(); tick();
    check("clrplay_busy_later", busy, 1'b0);
    check("clrplay_no_tx", tx_en_cnt - base_tx, 0);
    check("clrplay_no_done", done_cnt - base_done, 0);

    // rx and play in the same cycle
    base_tx = tx_en_cnt;
    rx_done = 1'b1;
    rxdata  = 8'h5A;
    play    = 1'b1;
    tick();
    rx_done = 1'b0;
    play    = 1'b0;
    check("rxp_we", bram_we, 1'b1);
    check("rxp_addr", bram_addr, 2'd0);
    check("rxp_idle", busy, 1'b0);
    tick();
    check("rxp_busy", busy, 1'b1);
    check("rxp_count", count, 3'd1);
    wait_done("rxp_done");
    check("rxp_tx_cnt", tx_en_cnt - base_tx, 1);
    check("rxp_byte", tx_log[base_tx & 63], 8'h5A);

    // async reset mid-SEND
    pulse_play();
    tick(); tick(); tick();
    check("pre_rst_tx_en", tx_en, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_tx_en", tx_en, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_count", count, 3'd0);
    check("arst_txdata", txdata, 8'h00);
    check("arst_addr", bram_addr, 2'd0);
    check("arst_datain", bram_datain, 8'h00);
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
